// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch responder.
// The FSM state encoding, the reset instruction and an alignment helper live here.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating request-timeout counter. It counts enabled cycles after a clear and
// flags expiry once TIMEOUT_CYCLES-1 is reached; it never wraps.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch responder: one single-beat memory read per instruction,
// valid/ready hand-off to decode, and inc/Disable control back to the PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_INSTR    = RV32I_NOP
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_val,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        pc_inc,
  output logic        pc_hold,
  output logic        fetch_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         mem_req_q, instr_valid_q, fetch_err_q;
  logic         tmr_clear, tmr_enable, tmr_expired;

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (clr),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  assign tmr_enable = ((state_q == REQ) || (state_q == DRAIN)) && !mem_ack;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    tmr_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          if (is_word_aligned(pc_val[1:0])) begin
            mem_addr_d = pc_val;
            tmr_clear  = 1'b1;
            state_d    = REQ;
          end else begin
            state_d = ERR;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!flush) begin
            instr_d    = mem_rdata;
            instr_pc_d = mem_addr_q;
            state_d    = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (flush) begin
          // The request stays up; the late response is swallowed in DRAIN.
          tmr_clear = 1'b1;
          state_d   = DRAIN;
        end else if (tmr_expired) begin
          state_d = ERR;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (tmr_expired) begin
          state_d = ERR;
        end
      end
      HOLD: begin
        if (flush || instr_ready) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      instr_q       <= RESET_INSTR;
      instr_pc_q    <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      mem_req_q     <= (state_d == REQ) || (state_d == DRAIN);
      instr_valid_q <= (state_d == HOLD);
      fetch_err_q   <= (state_d == ERR);
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

  // The accept pulse must land in the same cycle decode takes the word.
  assign pc_inc  = (state_q == HOLD) && instr_ready && !flush;
  assign pc_hold = (state_q != IDLE) && !pc_inc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations per cycle.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fetch_unit;

  logic        clk;
  logic        clr;
  logic [31:0] pc_val;
  logic        fetch_en;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_inc;
  logic        pc_hold;
  logic        fetch_err;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(
    .TIMEOUT_CYCLES(4),
    .RESET_INSTR   (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .pc_val     (pc_val),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_inc     (pc_inc),
    .pc_hold    (pc_hold),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply the cycle's inputs, settle.
  task automatic drive(input logic fe, input logic [31:0] pc, input logic ack,
                       input logic [31:0] rdata, input logic rdy, input logic fl);
    @(negedge clk);
    fetch_en    = fe;
    pc_val      = pc;
    mem_ack     = ack;
    mem_rdata   = rdata;
    instr_ready = rdy;
    flush       = fl;
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_mem_req"},     mem_req,     0);
    check_eq({tag, "_mem_addr"},    mem_addr,    0);
    check_eq({tag, "_instr"},       instr,       32'h0000_0013);
    check_eq({tag, "_instr_pc"},    instr_pc,    0);
    check_eq({tag, "_instr_valid"}, instr_valid, 0);
    check_eq({tag, "_pc_inc"},      pc_inc,      0);
    check_eq({tag, "_pc_hold"},     pc_hold,     0);
    check_eq({tag, "_fetch_err"},   fetch_err,   0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    #1;
  endtask

  initial begin
    clr = 1'b1; pc_val = '0; fetch_en = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_values("rst");
    clr = 1'b0;

    // Reset then fetch, zero-wait memory
    drive(1, 32'h100, 0, 0, 1, 0);
    check_eq("t1_c0_mem_req", mem_req, 0);
    check_eq("t1_c0_pc_hold", pc_hold, 0);
    drive(0, 32'h100, 1, 32'h0050_0093, 1, 0);
    check_eq("t1_c1_mem_req", mem_req, 1);
    check_eq("t1_c1_mem_addr", mem_addr, 32'h100);
    check_eq("t1_c1_pc_hold", pc_hold, 1);
    check_eq("t1_c1_pc_inc", pc_inc, 0);
    drive(0, 32'h100, 0, 0, 1, 0);
    check_eq("t1_c2_instr_valid", instr_valid, 1);
    check_eq("t1_c2_instr", instr, 32'h0050_0093);
    check_eq("t1_c2_instr_pc", instr_pc, 32'h100);
    check_eq("t1_c2_pc_inc", pc_inc, 1);
    check_eq("t1_c2_pc_hold", pc_hold, 0);
    check_eq("t1_c2_mem_req", mem_req, 0);
    drive(0, 32'h104, 0, 0, 1, 0);
    check_eq("t1_c3_instr_valid", instr_valid, 0);
    check_eq("t1_c3_pc_inc", pc_inc, 0);
    check_eq("t1_c3_pc_hold", pc_hold, 0);

    // Wait states (ack 3 cycles after request) and decode backpressure
    drive(1, 32'h104, 0, 0, 0, 0);
    check_eq("t2_a0_mem_req", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h104, 0, 0, 0, 0);
      check_eq("t2_wait_mem_req", mem_req, 1);
      check_eq("t2_wait_mem_addr", mem_addr, 32'h104);
      check_eq("t2_wait_pc_hold", pc_hold, 1);
    end
    drive(0, 32'h104, 1, 32'h00A0_0113, 0, 0);
    check_eq("t2_ack_mem_req", mem_req, 1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'h104, 0, 0, 0, 0);
      check_eq("t2_bp_instr_valid", instr_valid, 1);
      check_eq("t2_bp_pc_inc", pc_inc, 0);
      check_eq("t2_bp_pc_hold", pc_hold, 1);
      check_eq("t2_bp_mem_req", mem_req, 0);
    end
    drive(0, 32'h104, 0, 0, 1, 0);
    check_eq("t2_acc_instr_valid", instr_valid, 1);
    check_eq("t2_acc_pc_inc", pc_inc, 1);
    check_eq("t2_acc_instr", instr, 32'h00A0_0113);
    check_eq("t2_acc_instr_pc", instr_pc, 32'h104);
    drive(0, 32'h108, 0, 0, 0, 0);
    check_eq("t2_after_instr_valid", instr_valid, 0);
    check_eq("t2_after_instr", instr, 32'h00A0_0113);

    // Flush while waiting: request stays up, late data dropped
    drive(1, 32'h108, 0, 0, 0, 0);
    drive(0, 32'h108, 0, 0, 0, 0);
    check_eq("t3_req1_mem_req", mem_req, 1);
    drive(0, 32'h108, 0, 0, 0, 1);
    check_eq("t3_req2_mem_req", mem_req, 1);
    drive(0, 32'h108, 0, 0, 0, 0);
    check_eq("t3_drain_mem_req", mem_req, 1);
    check_eq("t3_drain_instr_valid", instr_valid, 0);
    check_eq("t3_drain_pc_hold", pc_hold, 1);
    drive(0, 32'h108, 1, 32'hDEAD_BEEF, 1, 0);
    check_eq("t3_ack_mem_req", mem_req, 1);
    check_eq("t3_ack_instr_valid", instr_valid, 0);
    drive(0, 32'h108, 0, 0, 1, 0);
    check_eq("t3_idle_mem_req", mem_req, 0);
    check_eq("t3_idle_instr_valid", instr_valid, 0);
    check_eq("t3_idle_instr", instr, 32'h00A0_0113);
    check_eq("t3_idle_instr_pc", instr_pc, 32'h104);
    check_eq("t3_idle_pc_hold", pc_hold, 0);
    check_eq("t3_idle_pc_inc", pc_inc, 0);

    // Flush in HOLD together with instr_ready
    drive(1, 32'h10C, 0, 0, 0, 0);
    drive(0, 32'h10C, 1, 32'h0000_0513, 0, 0);
    check_eq("t4_req_mem_addr", mem_addr, 32'h10C);
    drive(0, 32'h10C, 0, 0, 1, 1);
    check_eq("t4_hold_instr_valid", instr_valid, 1);
    check_eq("t4_hold_pc_inc", pc_inc, 0);
    check_eq("t4_hold_pc_hold", pc_hold, 1);
    drive(0, 32'h10C, 0, 0, 1, 0);
    check_eq("t4_next_instr_valid", instr_valid, 0);
    check_eq("t4_next_pc_inc", pc_inc, 0);
    check_eq("t4_next_instr", instr, 32'h0000_0513);

    // Misaligned PC goes straight to the sticky fault
    drive(1, 32'h102, 0, 0, 0, 0);
    check_eq("t6_c0_mem_req", mem_req, 0);
    check_eq("t6_c0_fetch_err", fetch_err, 0);
    drive(0, 32'h102, 0, 0, 0, 0);
    check_eq("t6_c1_mem_req", mem_req, 0);
    check_eq("t6_c1_fetch_err", fetch_err, 1);
    check_eq("t6_c1_pc_hold", pc_hold, 1);
    drive(1, 32'h200, 1, 32'h1234_5678, 1, 1);
    check_eq("t6_c2_fetch_err", fetch_err, 1);
    check_eq("t6_c2_mem_req", mem_req, 0);
    check_eq("t6_c2_instr_valid", instr_valid, 0);
    pulse_clr();
    check_reset_values("t6_clr");
    drive(0, 32'h200, 0, 0, 0, 0);
    clr = 1'b0;

    // Timeout with TIMEOUT_CYCLES=4 and no ack
    drive(1, 32'h200, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h200, 0, 0, 0, 0);
      check_eq("t5_req_mem_req", mem_req, 1);
      check_eq("t5_req_fetch_err", fetch_err, 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h200, 0, 0, 0, 0);
      check_eq("t5_err_fetch_err", fetch_err, 1);
      check_eq("t5_err_mem_req", mem_req, 0);
    end
    pulse_clr();
    check_reset_values("t5_clr");
    drive(0, 32'h200, 0, 0, 0, 0);
    clr = 1'b0;

    // clr mid-request, then a stray ack seen in IDLE must be ignored
    drive(1, 32'h300, 0, 0, 0, 0);
    drive(0, 32'h300, 0, 0, 0, 0);
    check_eq("t7_req_mem_req", mem_req, 1);
    check_eq("t7_req_mem_addr", mem_addr, 32'h300);
    pulse_clr();
    check_reset_values("t7_clr");
    drive(0, 32'h300, 1, 32'hCAFE_F00D, 1, 0);
    clr = 1'b0;
    drive(0, 32'h300, 1, 32'hCAFE_F00D, 1, 0);
    drive(0, 32'h300, 0, 0, 1, 0);
    check_eq("t7_stray_mem_req", mem_req, 0);
    check_eq("t7_stray_instr_valid", instr_valid, 0);
    check_eq("t7_stray_instr", instr, 32'h0000_0013);
    check_eq("t7_stray_pc_inc", pc_inc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch responder between the program counter register and instruction memory. Consumes the PC's address, performs one single-beat read per instruction on a request/acknowledge memory port, and presents the fetched word to decode with a valid/ready handshake. Produces the `inc` and `Disable` controls that advance or hold the PC, making it the other end of the PC's control interface.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: cycles in REQ without `mem_ack` before entering ERR; legal range 2..256.
- `RESET_INSTR`, 32'h0000_0013: value of `instr` after reset (RV32I NOP, `addi x0,x0,0`).

Ports:
- `clk` input 1: rising-edge clock.
- `clr` input 1: reset, asynchronous, active-high.
- `pc_val` input 32: current PC value.
- `fetch_en` input 1: core requests the next instruction.
- `flush` input 1: redirect; discard any in-flight or held instruction.
- `mem_req` output 1: read request, held until acknowledged.
- `mem_addr` output 32: word address of request.
- `mem_rdata` input 32: read data, valid when `mem_ack`=1.
- `mem_ack` input 1: one-cycle read completion.
- `instr` output 32: fetched instruction.
- `instr_pc` output 32: address `instr` was fetched from.
- `instr_valid` output 1: `instr` available to decode.
- `instr_ready` input 1: decode accepts `instr`.
- `pc_inc` output 1: to PC `inc`; one-cycle pulse.
- `pc_hold` output 1: to PC `Disable`.
- `fetch_err` output 1: sticky fault flag.

## Operation
- States: IDLE, REQ, DRAIN, HOLD, ERR.
- IDLE: if `fetch_en` and `pc_val[1:0]`==0, latch `pc_val` into `mem_addr` and go to REQ. If `fetch_en` and `pc_val[1:0]`!=0, go to ERR. Otherwise stay.
- REQ: `mem_req`=1, `mem_addr` stable. Timeout counter increments each cycle without ack.
  - `mem_ack` and no `flush`: capture `mem_rdata`→`instr`, `mem_addr`→`instr_pc`; go to HOLD.
  - `mem_ack` and `flush`: discard data; go to IDLE.
  - `flush` without ack: go to DRAIN. The request is not retracted.
  - No ack, counter = `TIMEOUT_CYCLES`-1: go to ERR.
- DRAIN: `mem_req`=1 until `mem_ack`. Data is discarded, then go to IDLE. `flush` is ignored. The timeout still applies.
- HOLD: `instr_valid`=1.
  - `instr_ready` and no `flush`: `pc_inc`=1 this cycle; go to IDLE.
  - `flush` (wins over `instr_ready`): no `pc_inc`; go to IDLE.
- ERR: `fetch_err`=1, `mem_req`=0, `instr_valid`=0. Exit only by `clr`.
- `pc_hold` = (state != IDLE) & ~`pc_inc`.
- `pc_inc` = (state == HOLD) & `instr_ready` & ~`flush`.
- `flush` in IDLE or ERR: no effect.
- Timeout counter clears on every entry to REQ or DRAIN. It is `$clog2(TIMEOUT_CYCLES)` bits wide and never wraps.

## Timing
- Reset values: state IDLE; `instr`=`RESET_INSTR`; `instr_pc`=0; `mem_addr`=0; counter=0. `mem_req`, `instr_valid`, `pc_inc`, `pc_hold`, `fetch_err` are all 0.
- `clr` mid-transaction returns to IDLE immediately. Any later `mem_ack` seen in IDLE is ignored.
- Zero-wait memory, with `fetch_en` at cycle 0:
  - `mem_req` at cycle 1; ack sampled in cycle 1.
  - `instr_valid` at cycle 2; with `instr_ready`=1, `pc_inc` at cycle 2.
  - PC updates at edge 3; next request no earlier than cycle 4.
  - Throughput is one instruction per 3 cycles minimum.
- `mem_ack` is sampled in any cycle `mem_req`=1, including the first.
- `instr`/`instr_pc` stay stable throughout HOLD and keep their last value afterward.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum (IDLE, REQ, DRAIN, HOLD, ERR) and the `RV32I_NOP` constant used as the default for `RESET_INSTR`.
- One sub-module, `fetch_timer`: a saturating counter with `clear`/`enable` inputs and an `expired` output, parameterised by `TIMEOUT_CYCLES`.
- The FSM, output registers and handshake logic live in `fetch_unit`.

## Test plan
- Reset then fetch:
  - Stimulus: `pc_val`=0x100, `fetch_en`=1, ack at cycle 1 with `mem_rdata`=0x00500093, `instr_ready`=1.
  - Required: `mem_addr`=0x100; `instr`=0x00500093 and `instr_pc`=0x100 at cycle 2; single `pc_inc` pulse; `pc_hold`=1 only in cycle 1.
- Wait states and backpressure:
  - Stimulus: ack 3 cycles after `mem_req`; `instr_ready` held low 2 cycles.
  - Required: `mem_req` held 4 cycles; `instr_valid` held 3 cycles; `pc_inc` only in the accept cycle.
- Flush while waiting:
  - Stimulus: `flush` in 2nd REQ cycle, ack 2 cycles later with 0xDEADBEEF.
  - Required: `mem_req` held until ack; `instr_valid` never asserts; `instr` retains its old value; returns to IDLE.
- Flush in HOLD together with `instr_ready`:
  - Required: no `pc_inc`; `instr_valid` drops the next cycle.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=4, no ack.
  - Required: ERR entered after 4 REQ cycles; `fetch_err`=1 and `mem_req`=0; both held until `clr`, then reset values.
- Misaligned PC:
  - Stimulus: `pc_val`=0x102, `fetch_en`=1.
  - Required: no `mem_req`; `fetch_err`=1 from the next cycle.
